// File: rtl/multi_bit_subtractor.sv
// multi_bit_subtractor
// Digit-serial unsigned subtractor: diff = a - b - bin over WIDTH bits,
// DIGIT bits per clock, with a registered borrow between digits.
// Operands enter and results leave through valid/ready handshakes.
// Optional build macro: SUB_SATURATE_EN clamps diff to 0 when the final
// borrow is set. bout still reports the borrow in that case.
module multi_bit_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] cell_ext;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] final_diff;

    // One digit worth of full-subtractor cells, rippling the borrow from the LSB
    always_comb begin
        logic br;
        br        = borrow;
        cell_diff = '0;
        for (int i = 0; i < DIGIT; i++) begin
            cell_diff[i] = a_sr[i] ^ b_sr[i] ^ br;
            br           = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & br);
        end
        cell_bout = br;
    end

    // Insert the new digit at the MSB end while the partial result shifts right
    always_comb begin
        cell_ext               = '0;
        cell_ext[DIGIT-1:0]    = cell_diff;
        res_next               = (res_sr >> DIGIT) | (cell_ext << (WIDTH - DIGIT));
`ifdef SUB_SATURATE_EN
        final_diff = cell_bout ? '0 : res_next;
`else
        final_diff = res_next;
`endif
    end

    // Handshake FSM and digit datapath; outputs are loaded once, on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            borrow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow   <= bin;
                        res_sr   <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    borrow <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff      <= final_diff;
                        bout      <= cell_bout;
                        zero      <= (final_diff == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_bit_subtractor.sv
// tb_multi_bit_subtractor
// Three instances (DIGIT = 4, 1, 16) share operands and out_ready; each has
// its own in_valid so they can accept independently. Expected results come
// from plain integer arithmetic and are queued per instance at issue time;
// a monitor process compares whatever each instance presents.
module tb_multi_bit_subtractor;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         opbin = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_valid [3];
    logic         in_ready [3];
    logic         out_valid [3];
    logic [W-1:0] diff [3];
    logic         bout [3];
    logic         zero [3];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_edge [3];
    logic prev_v [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    multi_bit_subtractor #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(opa), .b(opb), .bin(opbin), .out_valid(out_valid[0]), .out_ready(out_ready),
        .diff(diff[0]), .bout(bout[0]), .zero(zero[0])
    );

    multi_bit_subtractor #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(opa), .b(opb), .bin(opbin), .out_valid(out_valid[1]), .out_ready(out_ready),
        .diff(diff[1]), .bout(bout[1]), .zero(zero[1])
    );

    multi_bit_subtractor #(.WIDTH(W), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(opa), .b(opb), .bin(opbin), .out_valid(out_valid[2]), .out_ready(out_ready),
        .diff(diff[2]), .bout(bout[2]), .zero(zero[2])
    );

    function automatic int lat(int k);
        case (k)
            0:       return W / 4;
            1:       return W / 1;
            default: return W / 16;
        endcase
    endfunction

    function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, logic binv);
        exp_t e;
        int   d;
        d      = int'(av) - int'(bv) - int'(binv);
        e.bout = (d < 0);
        e.diff = W'(d);
`ifdef SUB_SATURATE_EN
        if (e.bout) e.diff = '0;
`endif
        e.zero = (e.diff == '0);
        return e;
    endfunction

    task automatic checkOutput(string name, int k, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, k, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(logic [W-1:0] av, logic [W-1:0] bv, logic binv);
        exp_t e;
        e     = model(av, bv, binv);
        opa   = av;
        opb   = bv;
        opbin = binv;
        q0.push_back(e);
        q1.push_back(e);
        q2.push_back(e);
        for (int k = 0; k < 3; k++) in_valid[k] = 1'b1;
    endtask

    task automatic waitAccept();
        logic rdy [3];
        int   g;
        g = 0;
        while ((in_valid[0] || in_valid[1] || in_valid[2]) && g < 200) begin
            for (int k = 0; k < 3; k++) rdy[k] = in_ready[k];
            step();
            for (int k = 0; k < 3; k++) begin
                if (in_valid[k] && rdy[k]) begin
                    in_valid[k] = 1'b0;
                    acc_edge[k] = cyc;
                end
            end
            g++;
        end
        for (int k = 0; k < 3; k++) begin
            if (in_valid[k]) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout dut%0d: got in_valid pending, expected acceptance", k);
                in_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && g < 500) begin
            step();
            g++;
        end
        checkOutput("drain_pending", 0, 32'(q0.size() + q1.size() + q2.size()), 0);
    endtask

    task automatic checkReset(string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput({tag, "_in_ready"}, k, 32'(in_ready[k]), 1);
            checkOutput({tag, "_out_valid"}, k, 32'(out_valid[k]), 0);
            checkOutput({tag, "_diff"}, k, 32'(diff[k]), 0);
            checkOutput({tag, "_bout"}, k, 32'(bout[k]), 0);
            checkOutput({tag, "_zero"}, k, 32'(zero[k]), 0);
        end
    endtask

    task automatic monitorStep();
        exp_t e;
        logic got;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k]) begin
                    if (!prev_v[k])
                        checkOutput("latency", k, 32'(cyc - acc_edge[k]), 32'(lat(k)));
                    got = 1'b0;
                    e   = '0;
                    case (k)
                        0: if (q0.size() != 0) begin
                            e = q0[0]; got = 1'b1;
                            if (out_ready) void'(q0.pop_front());
                        end
                        1: if (q1.size() != 0) begin
                            e = q1[0]; got = 1'b1;
                            if (out_ready) void'(q1.pop_front());
                        end
                        default: if (q2.size() != 0) begin
                            e = q2[0]; got = 1'b1;
                            if (out_ready) void'(q2.pop_front());
                        end
                    endcase
                    if (!got) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_valid dut%0d: got out_valid=1, expected no pending result", k);
                    end else begin
                        checkOutput("diff", k, 32'(diff[k]), 32'(e.diff));
                        checkOutput("bout", k, 32'(bout[k]), 32'(e.bout));
                        checkOutput("zero", k, 32'(zero[k]), 32'(e.zero));
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) prev_v[k] = out_valid[k];
    endtask

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus sequence with the scoreboard monitor forked alongside
    initial begin
        logic [W-1:0] da [4];
        logic [W-1:0] db [4];
        logic         dbin [4];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           rel;
        int           g;

        da   = '{16'h1234, 16'h0000, 16'hFFFF, 16'h5A5A};
        db   = '{16'h0234, 16'h0001, 16'hFFFF, 16'h5A5A};
        dbin = '{1'b0, 1'b0, 1'b1, 1'b0};

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            acc_edge[k] = 0;
            prev_v[k]   = 1'b0;
        end

        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        #1 rst_n = 1'b0;
        step();
        step();
        checkReset("reset");
        rst_n = 1'b1;
        step();

        $display("[TB] directed vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(da[i], db[i], dbin[i]);
            waitAccept();
        end
        drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(16'hABCD, 16'h1234, 1'b1);
        waitAccept();
        g = 0;
        while (!out_valid[0] && g < 50) begin
            step();
            g++;
        end
        checkOutput("bp_valid", 0, 32'(out_valid[0]), 1);
        applyStimulus(16'h0F0F, 16'h00FF, 1'b0);
        repeat (10) begin
            step();
            checkOutput("bp_in_ready", 0, 32'(in_ready[0]), 0);
            checkOutput("bp_out_valid", 0, 32'(out_valid[0]), 1);
        end
        rel       = cyc;
        out_ready = 1'b1;
        waitAccept();
        checkOutput("bp_accept_after_release", 0, 32'(acc_edge[0] > rel), 1);
        drain();

        $display("[TB] reset during RUN");
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h0101, 1'b0);
        waitAccept();
        step();
        rst_n = 1'b0;
        #1;
        checkReset("abort");
        q0.delete();
        q1.delete();
        q2.delete();
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (20) begin
            step();
            for (int k = 0; k < 3; k++)
                checkOutput("no_stale_valid", k, 32'(out_valid[k]), 0);
        end

        $display("[TB] random vectors");
        repeat (1000) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            applyStimulus(ra, rb, 1'($urandom));
            waitAccept();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_bit_subtractor.md
# multi_bit_subtractor

Parametrised, digit-serial unsigned subtractor: computes `diff = a - b - bin` over `WIDTH` bits, processing `DIGIT` bits per clock through a registered borrow chain of half/full-subtractor cells. It is the sequential, multi-bit successor to the team's single-bit subtractor cells. It sits in the datapath building-block library behind a valid/ready handshake on both sides, so it can be dropped between pipeline stages without glue logic.

## Interface
- `WIDTH`, default 16 — operand and result width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, default 4 — bits processed per cycle; range 1..`WIDTH`. Let `N = WIDTH/DIGIT`.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — operands `a`, `b`, `bin` are valid.
- `in_ready` out 1 — block can accept operands. High only in IDLE.
- `a` in `WIDTH` — minuend, unsigned.
- `b` in `WIDTH` — subtrahend, unsigned.
- `bin` in 1 — borrow-in.
- `out_valid` out 1 — result is valid. High only in DONE.
- `out_ready` in 1 — consumer accepts the result.
- `diff` out `WIDTH` — difference.
- `bout` out 1 — borrow-out; 1 iff `a < b + bin` (unsigned compare).
- `zero` out 1 — 1 iff the delivered `diff` equals 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1.
  - When `in_valid` is high, the block latches `a` and `b` into shift registers and loads `bin` into the borrow register.
  - It clears the digit counter and moves to RUN.
- RUN: each cycle the block subtracts the low `DIGIT` bits of the `a` and `b` registers, using the registered borrow as borrow-in.
  - The `DIGIT`-bit result enters the result register from the MSB end, and the result register shifts right by `DIGIT`.
  - The `a` and `b` registers shift right by `DIGIT`.
  - The cell's borrow-out updates the borrow register, and the counter increments.
  - After the N-th digit, the block goes to DONE.
- DONE: `out_valid`=1.
  - `diff`, `bout` and `zero` are held stable.
  - When `out_ready` is high, the result is consumed and the block returns to IDLE.
- Inputs are ignored outside IDLE. `a`, `b` and `bin` may change freely once captured.
- Result arithmetic is modulo 2^`WIDTH`. `bout` is the final borrow register value.
- `zero` is computed from the final `diff` after any saturation (see Configuration).

## Timing
- Reset (asynchronous assert, synchronous release) produces:
  - state IDLE, `in_ready`=1, `out_valid`=0;
  - `diff`=0, `bout`=0, `zero`=0;
  - counter, shift registers and borrow register all 0.
- Input handshake accepted at edge t: RUN spans edges t+1..t+N, and `out_valid` rises immediately after edge t+N.
  - Latency is N cycles from acceptance to `out_valid`.
- If `out_ready` is already high when `out_valid` rises, the result is consumed at edge t+N+1. `in_ready` is high after that edge, so the next input can be accepted at t+N+2.
  - Maximum throughput is one operation per N+2 cycles.
- With `out_ready` held low, DONE persists indefinitely and outputs do not change.
- `in_valid` during RUN or DONE has no effect; that transaction is not accepted.
- `rst_n` asserted during RUN or DONE aborts the operation immediately. No `out_valid` is produced for the aborted operands.
- `DIGIT`=`WIDTH` (N=1) must work with a 1-cycle RUN.

## Configuration
- `SUB_SATURATE_EN` defined: when the final borrow is 1, `diff` is forced to 0 (floor saturation).
  - `bout` still reports 1, and `zero` is 1.
  - Applied when the result is loaded on entry to DONE; latency is unchanged.
- `SUB_SATURATE_EN` undefined: `diff` wraps modulo 2^`WIDTH`, with no saturation logic in the design.

## Test plan
All scenarios use `WIDTH`=16, `DIGIT`=4 unless noted.
- `a`=0x1234, `b`=0x0234, `bin`=0 -> `diff`=0x1000, `bout`=0, `zero`=0. `out_valid` rises exactly 4 cycles after acceptance.
- `a`=0x0000, `b`=0x0001, `bin`=0 -> `bout`=1.
  - Without macro: `diff`=0xFFFF, `zero`=0.
  - With `SUB_SATURATE_EN`: `diff`=0x0000, `zero`=1.
- `a`=0xFFFF, `b`=0xFFFF, `bin`=1 -> `bout`=1; `diff`=0xFFFF without macro, 0x0000 with it.
- `a`=0x5A5A, `b`=0x5A5A, `bin`=0 -> `diff`=0, `zero`=1, `bout`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`, and drive a new `in_valid` throughout -> outputs stay stable, `in_ready`=0, and the new operands are accepted only after `out_ready` pulses.
- Assert `rst_n`=0 mid-RUN (cycle 2), then release -> all outputs take reset values at once. No stale `out_valid` appears. Rerun at `DIGIT`=1 and `DIGIT`=16 with a random 1000-vector compare against `a-b-bin` to confirm results match.
